deck_dealer: RTL and testbench

- Owns the 52-card shoe and serves single-card draw requests from two requesters: the player-side and dealer-side hand logic.
- Arbitrates round-robin between them, picks a start slot from the external random input, and linear-probes to the next occupied slot.
- Removes the card from the shoe and returns its 4-bit card identity with a one-cycle valid pulse.
- Sits between the game FSM and the hand/sum datapath; replaces ad-hoc deck indexing in the game FSM.

---
 rtl/blackjack_pkg.sv | 34 +++
 rtl/deal_arbiter.sv | 35 +++
 rtl/deck_dealer.sv | 120 ++++++++++++
 tb/tb_deck_dealer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared constants and types for the blackjack card path: shoe geometry,
// card identities, dealer FSM states and requester encoding.
package blackjack_pkg;

  localparam int NUM_CARDS = 52;
  localparam int RANKS     = 13;
  localparam int CARD_W    = 4;
  localparam int POS_W     = 6;

  localparam logic [CARD_W-1:0] CARD_NONE = 4'd0;
  localparam logic [CARD_W-1:0] AS        = 4'd1;
  localparam logic [CARD_W-1:0] DOIS      = 4'd2;
  localparam logic [CARD_W-1:0] TRES      = 4'd3;
  localparam logic [CARD_W-1:0] QUATRO    = 4'd4;
  localparam logic [CARD_W-1:0] CINCO     = 4'd5;
  localparam logic [CARD_W-1:0] SEIS      = 4'd6;
  localparam logic [CARD_W-1:0] SETE      = 4'd7;
  localparam logic [CARD_W-1:0] OITO      = 4'd8;
  localparam logic [CARD_W-1:0] NOVE      = 4'd9;
  localparam logic [CARD_W-1:0] DEZ       = 4'd10;
  localparam logic [CARD_W-1:0] VALETE    = 4'd11;
  localparam logic [CARD_W-1:0] DAMA      = 4'd12;
  localparam logic [CARD_W-1:0] REI       = 4'd13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBE   = 2'd1,
    DELIVER = 2'd2
  } deal_state_t;

  localparam logic PLAYER = 1'b0;
  localparam logic DEALER = 1'b1;

endpackage

// File: rtl/deal_arbiter.sv
// Two-way round-robin arbiter: combinational winner, last_grant registered
// when a card is actually delivered (not when a request is accepted).
module deal_arbiter
  import blackjack_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_player,
  input  logic req_dealer,
  input  logic served,
  input  logic served_id,
  output logic winner
);

  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= DEALER;
    end else if (served) begin
      last_grant <= served_id;
    end
  end

  // On a tie the requester opposite the last one served wins.
  always_comb begin
    winner = ~last_grant;
    if (req_player && !req_dealer) begin
      winner = PLAYER;
    end else if (req_dealer && !req_player) begin
      winner = DEALER;
    end
  end

endmodule

// File: rtl/deck_dealer.sv
// 52-card shoe with round-robin draw service and linear probing from a random
// start slot. Optional per-requester deal counters under BLACKJACK_DEAL_COUNT_EN.
module deck_dealer
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              new_deck,
  input  logic              req_player,
  input  logic              req_dealer,
  input  logic [POS_W-1:0]  random,
  output logic              grant_player,
  output logic              grant_dealer,
  output logic              card_valid,
  output logic [CARD_W-1:0] card,
  output logic [POS_W-1:0]  cards_left,
  output logic              deck_empty,
  output logic              busy
`ifdef BLACKJACK_DEAL_COUNT_EN
  ,
  output logic [3:0]        player_count,
  output logic [3:0]        dealer_count
`endif
);

  localparam logic [POS_W-1:0] FULL_COUNT = POS_W'(NUM_CARDS);
  localparam logic [POS_W-1:0] LAST_SLOT  = POS_W'(NUM_CARDS - 1);

  deal_state_t          state, state_next;
  logic [NUM_CARDS-1:0] mask;
  logic [POS_W-1:0]     pos;
  logic                 owner;
  logic                 winner;
  logic                 accept;
  logic                 hit;

  // Handshake: a request is a level held until its grant; grant and
  // card_valid are a single-cycle pulse in DELIVER, which completes the draw.
  assign accept = (state == IDLE) && !new_deck && (req_player || req_dealer) && !deck_empty;
  assign hit    = mask[pos];

  assign busy         = (state != IDLE);
  assign card_valid   = (state == DELIVER);
  assign grant_player = card_valid && (owner == PLAYER);
  assign grant_dealer = card_valid && (owner == DEALER);

  deal_arbiter u_arb (
    .clk        (clk),
    .rst        (reset),
    .req_player (req_player),
    .req_dealer (req_dealer),
    .served     (card_valid),
    .served_id  (owner),
    .winner     (winner)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PROBE;
      PROBE:   if (hit) state_next = DELIVER;
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mask       <= '1;
      cards_left <= FULL_COUNT;
      deck_empty <= 1'b0;
      card       <= CARD_NONE;
      pos        <= '0;
      owner      <= PLAYER;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (new_deck) begin
            mask       <= '1;
            cards_left <= FULL_COUNT;
            deck_empty <= 1'b0;
          end else if (accept) begin
            owner <= winner;
            // Fold the 64-value seed onto the 52 slots.
            pos   <= (random >= FULL_COUNT) ? (random - FULL_COUNT) : random;
          end
        end
        PROBE: begin
          if (hit) begin
            mask[pos]  <= 1'b0;
            card       <= AS + CARD_W'(pos % POS_W'(RANKS));
            cards_left <= cards_left - 1'b1;
            deck_empty <= (cards_left == POS_W'(1));
          end else begin
            pos <= (pos == LAST_SLOT) ? '0 : pos + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLACKJACK_DEAL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_count <= '0;
      dealer_count <= '0;
    end else if ((state == IDLE) && new_deck) begin
      player_count <= '0;
      dealer_count <= '0;
    end else begin
      if (grant_player && (player_count != 4'hF)) player_count <= player_count + 1'b1;
      if (grant_dealer && (dealer_count != 4'hF)) dealer_count <= dealer_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: fixed vectors, round-robin sequence, async reset,
// randomized draws against a shoe model, exhaustion and refill.
module tb_deck_dealer;

  logic       clk = 1'b0;
  logic       reset, new_deck, req_player, req_dealer;
  logic [5:0] random;
  logic       grant_player, grant_dealer, card_valid;
  logic [3:0] card;
  logic [5:0] cards_left;
  logic       deck_empty, busy;
`ifdef BLACKJACK_DEAL_COUNT_EN
  logic [3:0] player_count, dealer_count;
`endif

  always #5 clk = ~clk;

  deck_dealer dut (
    .clk          (clk),
    .reset        (reset),
    .new_deck     (new_deck),
    .req_player   (req_player),
    .req_dealer   (req_dealer),
    .random       (random),
    .grant_player (grant_player),
    .grant_dealer (grant_dealer),
    .card_valid   (card_valid),
    .card         (card),
    .cards_left   (cards_left),
    .deck_empty   (deck_empty),
    .busy         (busy)
`ifdef BLACKJACK_DEAL_COUNT_EN
    ,
    .player_count (player_count),
    .dealer_count (dealer_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Shoe model: presence per slot, count, last served requester.
  bit         present[52];
  int         left;
  bit         last_dealer;
  logic [3:0] exp_q[$];

  typedef struct {
    bit         rp;
    bit         rd;
    logic [5:0] rnd;
    int         exp_card;
    int         exp_lat;
    int         exp_left;
    bit         exp_dealer;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_refill();
    foreach (present[i]) present[i] = 1'b1;
    left = 52;
  endtask

  task automatic model_step(input bit rp, input bit rd, input logic [5:0] rnd,
                            output int skipped, output bit win_dealer);
    int start;
    if (rp && !rd) win_dealer = 1'b0;
    else if (rd && !rp) win_dealer = 1'b1;
    else win_dealer = !last_dealer;
    last_dealer = win_dealer;
    start = int'(rnd) % 52;
    skipped = 0;
    for (int i = 0; i < 52; i++) begin
      int s;
      s = (start + i) % 52;
      if (present[s]) begin
        present[s] = 1'b0;
        left--;
        skipped = i;
        exp_q.push_back(4'(s % 13 + 1));
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the delivery cycle.
  task automatic do_draw(input bit rp, input bit rd, input logic [5:0] rnd, input bit hold,
                         output int lat, output int got, output bit gp, output bit gd,
                         output int left_now, output bit empty_now);
    req_player = rp;
    req_dealer = rd;
    random     = rnd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!card_valid && lat < 80);
    check("draw_done", int'(card_valid), 1);
    got       = int'(card);
    gp        = grant_player;
    gd        = grant_dealer;
    left_now  = int'(cards_left);
    empty_now = deck_empty;
    if (!hold) begin
      req_player = 1'b0;
      req_dealer = 1'b0;
    end
    @(negedge clk);
    check("single_pulse", int'({card_valid, grant_player, grant_dealer}), 0);
  endtask

  task automatic draw_check(input bit rp, input bit rd, input logic [5:0] rnd, input bit hold,
                            output bit got_dealer);
    int skipped, lat, got, left_now;
    bit wd, gp, gd, empty_now;
    model_step(rp, rd, rnd, skipped, wd);
    do_draw(rp, rd, rnd, hold, lat, got, gp, gd, left_now, empty_now);
    if (exp_q.size() > 0) check("card", got, int'(exp_q.pop_front()));
    check("latency", lat, skipped + 2);
    check("grant_player", int'(gp), int'(!wd));
    check("grant_dealer", int'(gd), int'(wd));
    check("cards_left", left_now, left);
    check("deck_empty", int'(empty_now), int'(left == 0));
    got_dealer = gd;
  endtask

  initial begin
    bit gd_seen;
    reset = 1'b0; new_deck = 1'b0; req_player = 1'b0; req_dealer = 1'b0; random = '0;

    // Async reset asserted mid-cycle, outputs checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_deck_empty", int'(deck_empty), 0);
    check("rst_card", int'(card), 0);
    check("rst_pulses", int'({card_valid, grant_player, grant_dealer, busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    model_refill();
    last_dealer = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 6'd0,  1,  2, 51, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 6'd0,  2,  3, 50, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 6'd25, 13, 2, 49, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 6'd60, 9,  2, 48, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 6'd63, 12, 2, 47, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 6'd51, 13, 2, 46, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 6'd51, 3,  5, 45, 1'b1};

    for (int i = 0; i < 7; i++) begin
      int skipped, lat, got, left_now;
      bit wd, gp, gd, empty_now;
      model_step(vecs[i].rp, vecs[i].rd, vecs[i].rnd, skipped, wd);
      void'(exp_q.pop_front());
      do_draw(vecs[i].rp, vecs[i].rd, vecs[i].rnd, 1'b0, lat, got, gp, gd, left_now, empty_now);
      check($sformatf("vec%0d_card", i), got, vecs[i].exp_card);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_cards_left", i), left_now, vecs[i].exp_left);
      check($sformatf("vec%0d_grant_dealer", i), int'(gd), int'(vecs[i].exp_dealer));
      check($sformatf("vec%0d_grant_player", i), int'(gp), int'(!vecs[i].exp_dealer));
    end

    // Both requests held: last served was the dealer, so P,D,P,D.
    for (int i = 0; i < 4; i++) begin
      draw_check(1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b1, gd_seen);
      check($sformatf("alt_order%0d", i), int'(gd_seen), i % 2);
    end
    req_player = 1'b0;
    req_dealer = 1'b0;
    @(negedge clk);

    // Reset in the middle of a draw aborts it and refills the shoe.
    req_player = 1'b1;
    random = 6'd7;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_pulses", int'({card_valid, grant_player, grant_dealer}), 0);
    check("midrst_cards_left", int'(cards_left), 52);
    check("midrst_card", int'(card), 0);
    @(negedge clk);
    reset = 1'b0;
    req_player = 1'b0;
    model_refill();
    last_dealer = 1'b1;
    exp_q.delete();
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      draw_check(sel != 1, sel != 0, 6'($urandom_range(0, 63)), 1'b0, gd_seen);
    end

    while (left > 0) begin
      int sel;
      sel = $urandom_range(0, 2);
      draw_check(sel != 1, sel != 0, 6'($urandom_range(0, 63)), 1'b0, gd_seen);
    end
    check("empty_cards_left", int'(cards_left), 0);
    check("empty_flag", int'(deck_empty), 1);

    // Requests on an empty shoe are never granted.
    req_player = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("empty_no_grant", int'({card_valid, grant_player, grant_dealer, busy}), 0);
    end

    new_deck = 1'b1;
    @(negedge clk);
    new_deck = 1'b0;
    check("refill_cards_left", int'(cards_left), 52);
    check("refill_deck_empty", int'(deck_empty), 0);
    check("refill_busy", int'(busy), 0);
    model_refill();
    draw_check(1'b1, 1'b0, 6'($urandom_range(0, 63)), 1'b0, gd_seen);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
